sccb_slave_regfile: RTL and testbench
=====================================

Name: sccb_slave_regfile

Overview:
- SCCB/I2C target that models the camera end of the configuration bus.
- Receives the register-address/data pairs that the camera init sequencer writes, stores them in a 256x8 register file, and answers reads.
- Used in simulation and on-board loopback to check camera configuration tables without a sensor attached.
- Also gives the fabric a monitor/readback port.

Parameters:
- DEV_ADDR, 7'h21, 7-bit target ID (8'h42 write, 8'h43 read).
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- scl_in  in  1  bus clock, input only
- sda_in  in  1  bus data as seen on the wire
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA
- wr_valid  out  1  one-cycle pulse per committed register write
- wr_addr  out  8  register address of the committed write
- wr_data  out  8  data of the committed write
- busy  out  1  high from START to STOP
- dbg_addr  in  8  readback address
- dbg_data  out  8  reg[dbg_addr], registered

Behaviour:
- Reset (async): state IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, dbg_data=0, pointer=0, all 256 registers cleared to 8'h00.
- Input conditioning: scl_in/sda_in pass through SYNC_STAGES flops plus one history flop.
- Edge detection on the synchronized signals:
  - rise = SCL 0→1.
  - fall = SCL 1→0.
  - START = SDA 1→0 while SCL high.
  - STOP = SDA 0→1 while SCL high.
- Bus timing requirement: SCL high and low phases each ≥ SYNC_STAGES+3 clk.
- Bits are sampled MSB-first on rise. sda_oe changes only on fall, or on START/STOP/reset.
- States: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
- START in any state → DEV, bit counter=0, busy=1, sda_oe=0. This covers repeated START.
- STOP in any state → IDLE, busy=0, sda_oe=0. STOP wins over a simultaneous rise/fall decode.
- DEV:
  - Collect 8 bits.
  - On the 8th rise: if bits[7:1]==DEV_ADDR and R/W=0 → DEV_ACK(write); if R/W=1 → DEV_ACK(read).
  - Mismatch → WAIT_STOP; sda_oe is never asserted.
- Any *_ACK state driven by the target (DEV_ACK, SUB_ACK, WR_ACK):
  - Next fall → sda_oe=1.
  - Following fall → sda_oe=0.
  - Then advance: DEV_ACK(write)→SUB, DEV_ACK(read)→RD, SUB_ACK→WR, WR_ACK→WR.
- SUB: 8 bits; the 8th rise loads pointer ← byte.
- WR: 8 bits; the 8th rise commits reg[pointer] ← byte.
  - Next clk: wr_valid=1 for exactly 1 cycle, wr_addr=old pointer, wr_data=byte.
  - pointer ← pointer+1, wrapping 8'hFF→8'h00.
  - Consecutive data bytes in one transaction are burst writes.
- RD:
  - On entry, shift register ← reg[pointer].
  - Each fall drives sda_oe = ~current bit (bit7 first, starting at the fall that ends the ACK).
  - After 8 bits, on the next fall: sda_oe=0 and pointer ← pointer+1 (wraps).
  - Go to RD_ACK.
- RD_ACK: sample sda_in on rise.
  - 0 (initiator ACK) → RD, next byte.
  - 1 (NACK) → WAIT_STOP.
- WAIT_STOP: sda_oe=0; only START or STOP leaves this state.
- Pointer survives STOP and repeated START, so a 2-phase read returns the last written sub-address.
- dbg_data <= reg[dbg_addr] every clk (latency 1). A same-cycle commit to that address shows the new value one cycle later.
- Reset mid-transfer: sda_oe drops to 0 asynchronously. The target ignores the bus until the next START.

Test Plan:
- Write 0x42, 0x12, 0x04, STOP → ACK low on all three 9th clocks; one wr_valid with addr 0x12, data 0x04; dbg_addr=0x12 → dbg_data=0x04; busy low after STOP.
- Write 0x42, 0xFF, 0xAA, 0x55 → two wr_valid pulses, (0xFF,0xAA) then (0x00,0x55); pointer wraps to 0x01.
- Write 0x42, 0x40, 0xD0, STOP; then 0x43 and read one byte with NACK, STOP → after the write pointer=0x41, so the 2-phase read returns reg[0x41]=0x00. Then write 0x42, 0x40, STOP; 0x43 read → SDA carries 0xD0, sda_oe released on the 9th bit, state reaches WAIT_STOP.
- Wrong ID 0x60 followed by two bytes → sda_oe stays 0 throughout; no wr_valid; a later valid transaction works.
- 0x42, 0x3A, then repeated START, 0x43, read with ACK then NACK → returns reg[0x3A] then reg[0x3B]; no write committed.
- Assert rst while sda_oe=1 during an ACK → sda_oe=0 in the same cycle; dbg readback of previously written registers returns 0x00; next full write succeeds.

Source files
------------

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C target backed by a 256x8 register file.
// Emulates the camera side of the config bus, plus a fabric readback port.
module sccb_slave_regfile #(
   parameter logic [6:0] DEV_ADDR    = 7'h21,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic [3:0] {
      IDLE,
      DEV,
      DEV_ACK,
      SUB,
      SUB_ACK,
      WR,
      WR_ACK,
      RD,
      RD_ACK,
      WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_ff;
   logic [SYNC_STAGES-1:0] sda_ff;
   logic                   scl_h;
   logic                   sda_h;
   logic                   scl_s;
   logic                   sda_s;
   logic                   rise;
   logic                   fall;
   logic                   start;
   logic                   stop;

   state_t     state;
   state_t     state_d;
   logic [3:0] cnt;
   logic [3:0] cnt_d;
   logic [7:0] rx_sh;
   logic [7:0] rx_d;
   logic [7:0] tx_sh;
   logic [7:0] tx_d;
   logic       rd_mode;
   logic       rd_mode_d;
   logic       ack_drv;
   logic       ack_d;
   logic       oe_d;
   logic       busy_d;
   logic [7:0] ptr;
   logic [7:0] ptr_d;
   logic       wv_d;
   logic [7:0] wa_d;
   logic [7:0] wd_d;
   logic       we;
   logic [7:0] rx_byte;
   logic [7:0] rd_byte;

   logic [7:0] regs [256];

   // Synchronizers reset low so release cannot fake a START/STOP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_ff <= '0;
         sda_ff <= '0;
         scl_h  <= 1'b0;
         sda_h  <= 1'b0;
      end else begin
         scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
         sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
         scl_h  <= scl_ff[SYNC_STAGES-1];
         sda_h  <= sda_ff[SYNC_STAGES-1];
      end
   end

   assign scl_s   = scl_ff[SYNC_STAGES-1];
   assign sda_s   = sda_ff[SYNC_STAGES-1];
   assign rise    = scl_s & ~scl_h;
   assign fall    = ~scl_s & scl_h;
   assign start   = scl_s & scl_h & sda_h & ~sda_s;
   assign stop    = scl_s & scl_h & ~sda_h & sda_s;
   assign rx_byte = {rx_sh[6:0], sda_s};
   assign rd_byte = regs[ptr];

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      rx_d      = rx_sh;
      tx_d      = tx_sh;
      rd_mode_d = rd_mode;
      ack_d     = ack_drv;
      oe_d      = sda_oe;
      busy_d    = busy;
      ptr_d     = ptr;
      wv_d      = 1'b0;
      wa_d      = wr_addr;
      wd_d      = wr_data;
      we        = 1'b0;
      if (stop) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         oe_d    = 1'b0;
         ack_d   = 1'b0;
      end else if (start) begin
         state_d = DEV;
         cnt_d   = '0;
         busy_d  = 1'b1;
         oe_d    = 1'b0;
         ack_d   = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
            end
            DEV: begin
               if (rise) begin
                  rx_d  = rx_byte;
                  cnt_d = cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt_d = '0;
                     if (rx_byte[7:1] == DEV_ADDR) begin
                        state_d   = DEV_ACK;
                        rd_mode_d = rx_byte[0];
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end
            SUB: begin
               if (rise) begin
                  rx_d  = rx_byte;
                  cnt_d = cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt_d   = '0;
                     ptr_d   = rx_byte;
                     state_d = SUB_ACK;
                  end
               end
            end
            WR: begin
               if (rise) begin
                  rx_d  = rx_byte;
                  cnt_d = cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt_d   = '0;
                     we      = 1'b1;
                     wv_d    = 1'b1;
                     wa_d    = ptr;
                     wd_d    = rx_byte;
                     ptr_d   = ptr + 8'd1;
                     state_d = WR_ACK;
                  end
               end
            end
            DEV_ACK, SUB_ACK, WR_ACK: begin
               if (fall) begin
                  if (!ack_drv) begin
                     oe_d  = 1'b1;
                     ack_d = 1'b1;
                  end else begin
                     ack_d = 1'b0;
                     oe_d  = 1'b0;
                     cnt_d = '0;
                     if (state != DEV_ACK) begin
                        state_d = WR;
                     end else if (!rd_mode) begin
                        state_d = SUB;
                     end else begin
                        // This fall both ends the ACK and presents bit 7
                        state_d = RD;
                        oe_d    = ~rd_byte[7];
                        tx_d    = {rd_byte[6:0], 1'b0};
                        cnt_d   = 4'd1;
                     end
                  end
               end
            end
            RD: begin
               if (fall) begin
                  if (cnt == 4'd8) begin
                     oe_d    = 1'b0;
                     ptr_d   = ptr + 8'd1;
                     cnt_d   = '0;
                     state_d = RD_ACK;
                  end else begin
                     oe_d  = ~tx_sh[7];
                     tx_d  = {tx_sh[6:0], 1'b0};
                     cnt_d = cnt + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (rise) begin
                  if (sda_s) begin
                     state_d = WAIT_STOP;
                  end else begin
                     state_d = RD;
                     tx_d    = rd_byte;
                     cnt_d   = '0;
                  end
               end
            end
            WAIT_STOP: begin
               oe_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rx_sh    <= '0;
         tx_sh    <= '0;
         rd_mode  <= 1'b0;
         ack_drv  <= 1'b0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         ptr      <= '0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         rx_sh    <= rx_d;
         tx_sh    <= tx_d;
         rd_mode  <= rd_mode_d;
         ack_drv  <= ack_d;
         sda_oe   <= oe_d;
         busy     <= busy_d;
         ptr      <= ptr_d;
         wr_valid <= wv_d;
         wr_addr  <= wa_d;
         wr_data  <= wd_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) begin
            regs[i] <= '0;
         end
         dbg_data <= '0;
      end else begin
         if (we) begin
            regs[ptr] <= rx_byte;
         end
         dbg_data <= regs[dbg_addr];
      end
   end

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench for sccb_slave_regfile.
// Drives a wired-AND SDA bus model and checks acks, writes, reads, readback.
module tb_sccb_slave_regfile;

   localparam time T = 50ns;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic       sda_in;
   logic       sda_oe;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic [7:0] dbg_addr;
   logic [7:0] dbg_data;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [15:0] wq[$];
   logic        oe_seen;

   always #5ns clk = ~clk;

   assign sda_in = sda_m & ~sda_oe;

   sccb_slave_regfile #(
      .DEV_ADDR   (7'h21),
      .SYNC_STAGES(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .scl_in  (scl),
      .sda_in  (sda_in),
      .sda_oe  (sda_oe),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   always @(negedge clk) begin
      if (wr_valid) wq.push_back({wr_addr, wr_data});
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic bus_start();
      #T sda_m = 1'b1;
      #T scl = 1'b1;
      #T sda_m = 1'b0;
      #T scl = 1'b0;
   endtask

   task automatic bus_stop();
      #T sda_m = 1'b0;
      #T scl = 1'b1;
      #T sda_m = 1'b1;
      #T;
   endtask

   task automatic clk_bit(input logic drv, output logic smp, output logic oe_s);
      #T sda_m = drv;
      #T scl = 1'b1;
      #T;
      smp  = sda_in;
      oe_s = sda_oe;
      #T scl = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] b);
      logic s, o;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s, o);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic o;
      send_bits(b);
      clk_bit(1'b1, ack, o);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d, output logic oe9);
      logic s, o;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s, o);
         d[i] = s;
      end
      clk_bit(nack, s, oe9);
   endtask

   task automatic dbg_read(input logic [7:0] a, output logic [7:0] d);
      dbg_addr = a;
      repeat (2) @(negedge clk);
      d = dbg_data;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1;
      scl = 1'b1;
      sda_m = 1'b1;
      dbg_addr = 8'h00;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({sda_oe, wr_valid, busy} !== 3'b000)
         $display("FAIL reset_ctrl got %b want 000", {sda_oe, wr_valid, busy});
      else pass_cnt++;
      chk_cnt++;
      if ({wr_addr, wr_data, dbg_data} !== 24'h0)
         $display("FAIL reset_data got %h want 000000", {wr_addr, wr_data, dbg_data});
      else pass_cnt++;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      dbg_read(8'h12, d);
      chk_cnt++;
      if (d !== 8'h00) $display("FAIL reset_reg got %h want 00", d);
      else pass_cnt++;
   endtask

   task automatic test_single_write();
      logic a0, a1, a2;
      logic [7:0] d;
      logic [15:0] got;
      wq.delete();
      bus_start();
      #T;
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL busy_start got %b want 1", busy);
      else pass_cnt++;
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      send_byte(8'h04, a2);
      bus_stop();
      repeat (4) @(negedge clk);
      chk_cnt++;
      if ({a0, a1, a2} !== 3'b000) $display("FAIL wr_acks got %b want 000", {a0, a1, a2});
      else pass_cnt++;
      chk_cnt++;
      if (wq.size() !== 1) $display("FAIL wr_count got %0d want 1", wq.size());
      else pass_cnt++;
      got = (wq.size() > 0) ? wq[0] : 16'hxxxx;
      chk_cnt++;
      if (got !== 16'h1204) $display("FAIL wr_pulse got %h want 1204", got);
      else pass_cnt++;
      dbg_read(8'h12, d);
      chk_cnt++;
      if (d !== 8'h04) $display("FAIL dbg_12 got %h want 04", d);
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL busy_stop got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_burst_wrap();
      logic a0, a1, a2, a3;
      logic [7:0] d;
      logic [15:0] g0, g1;
      wq.delete();
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'hFF, a1);
      send_byte(8'hAA, a2);
      send_byte(8'h55, a3);
      bus_stop();
      repeat (4) @(negedge clk);
      chk_cnt++;
      if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL burst_acks got %b want 0000", {a0, a1, a2, a3});
      else pass_cnt++;
      chk_cnt++;
      if (wq.size() !== 2) $display("FAIL burst_count got %0d want 2", wq.size());
      else pass_cnt++;
      g0 = (wq.size() > 0) ? wq[0] : 16'hxxxx;
      g1 = (wq.size() > 1) ? wq[1] : 16'hxxxx;
      chk_cnt++;
      if (g0 !== 16'hFFAA) $display("FAIL burst_first got %h want FFAA", g0);
      else pass_cnt++;
      chk_cnt++;
      if (g1 !== 16'h0055) $display("FAIL burst_wrap got %h want 0055", g1);
      else pass_cnt++;
      dbg_read(8'h00, d);
      chk_cnt++;
      if (d !== 8'h55) $display("FAIL dbg_00 got %h want 55", d);
      else pass_cnt++;
   endtask

   task automatic test_two_phase_read();
      logic a0, a1, a2, o9;
      logic [7:0] d;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h40, a1);
      send_byte(8'hD0, a2);
      bus_stop();
      bus_start();
      send_byte(8'h43, a0);
      recv_byte(1'b1, d, o9);
      bus_stop();
      chk_cnt++;
      if (d !== 8'h00) $display("FAIL rd_after_wr got %h want 00", d);
      else pass_cnt++;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h40, a1);
      bus_stop();
      bus_start();
      send_byte(8'h43, a2);
      recv_byte(1'b1, d, o9);
      chk_cnt++;
      if ({a0, a1, a2} !== 3'b000) $display("FAIL rd_acks got %b want 000", {a0, a1, a2});
      else pass_cnt++;
      chk_cnt++;
      if (d !== 8'hD0) $display("FAIL rd_data got %h want D0", d);
      else pass_cnt++;
      chk_cnt++;
      if (o9 !== 1'b0) $display("FAIL rd_release got %b want 0", o9);
      else pass_cnt++;
      oe_seen = 1'b0;
      recv_byte(1'b1, d, o9);
      chk_cnt++;
      if (oe_seen !== 1'b0) $display("FAIL wait_stop_oe got %b want 0", oe_seen);
      else pass_cnt++;
      bus_stop();
   endtask

   task automatic test_wrong_id();
      logic a0, a1, a2;
      logic [15:0] got;
      wq.delete();
      oe_seen = 1'b0;
      bus_start();
      send_byte(8'h60, a0);
      send_byte(8'h20, a1);
      send_byte(8'h99, a2);
      bus_stop();
      repeat (4) @(negedge clk);
      chk_cnt++;
      if ({a0, a1, a2, oe_seen} !== 4'b1110)
         $display("FAIL bad_id_bus got %b want 1110", {a0, a1, a2, oe_seen});
      else pass_cnt++;
      chk_cnt++;
      if (wq.size() !== 0) $display("FAIL bad_id_write got %0d want 0", wq.size());
      else pass_cnt++;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h20, a1);
      send_byte(8'h99, a2);
      bus_stop();
      repeat (4) @(negedge clk);
      got = (wq.size() > 0) ? wq[0] : 16'hxxxx;
      chk_cnt++;
      if (got !== 16'h2099) $display("FAIL after_bad_id got %h want 2099", got);
      else pass_cnt++;
   endtask

   task automatic test_repeated_start();
      logic a0, a1, a2, a3, o9;
      logic [7:0] d0, d1;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h3A, a1);
      send_byte(8'h11, a2);
      send_byte(8'h22, a3);
      bus_stop();
      wq.delete();
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h3A, a1);
      bus_start();
      send_byte(8'h43, a2);
      recv_byte(1'b0, d0, o9);
      recv_byte(1'b1, d1, o9);
      bus_stop();
      repeat (4) @(negedge clk);
      chk_cnt++;
      if ({a0, a1, a2} !== 3'b000) $display("FAIL rs_acks got %b want 000", {a0, a1, a2});
      else pass_cnt++;
      chk_cnt++;
      if ({d0, d1} !== 16'h1122) $display("FAIL rs_data got %h want 1122", {d0, d1});
      else pass_cnt++;
      chk_cnt++;
      if (wq.size() !== 0) $display("FAIL rs_no_write got %0d want 0", wq.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_ack();
      logic a0, a1, a2;
      logic [7:0] d;
      logic [15:0] got;
      bus_start();
      send_byte(8'h42, a0);
      send_bits(8'h12);
      #(2*T) sda_m = 1'b1;
      chk_cnt++;
      if (sda_oe !== 1'b1) $display("FAIL ack_driven got %b want 1", sda_oe);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++;
      if (sda_oe !== 1'b0) $display("FAIL async_rst_oe got %b want 0", sda_oe);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus_stop();
      dbg_read(8'h40, d);
      chk_cnt++;
      if (d !== 8'h00) $display("FAIL rst_clear_40 got %h want 00", d);
      else pass_cnt++;
      dbg_read(8'h3A, d);
      chk_cnt++;
      if (d !== 8'h00) $display("FAIL rst_clear_3a got %h want 00", d);
      else pass_cnt++;
      wq.delete();
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      send_byte(8'h77, a2);
      bus_stop();
      repeat (4) @(negedge clk);
      got = (wq.size() > 0) ? wq[0] : 16'hxxxx;
      chk_cnt++;
      if ({a0, a1, a2} !== 3'b000 || got !== 16'h1277)
         $display("FAIL post_rst_write got %b/%h want 000/1277", {a0, a1, a2}, got);
      else pass_cnt++;
      dbg_read(8'h12, d);
      chk_cnt++;
      if (d !== 8'h77) $display("FAIL post_rst_dbg got %h want 77", d);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_wrap();
      test_two_phase_read();
      test_wrong_id();
      test_repeated_start();
      test_reset_mid_ack();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
